fnd_scan_controller: RTL and testbench

- Sequencer for a 4-digit common-anode seven-segment (FND) display.
- Accepts a binary value 0..9999, converts it to four BCD digits with a multi-cycle double-dabble engine, and time-multiplexes those digits onto a single shared BCD-to-FND decoder.
- Drives the decoder's 4-bit input (o_bcd) and the active-low digit-enable lines.
- Sits between the MicroBlaze GPIO value register and the decoder/board pins.

---
 rtl/fnd_scan_controller.sv | 130 +++++++++++++
 tb/tb_fnd_scan_controller.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// 4-digit common-anode FND sequencer: serial double-dabble binary-to-BCD conversion
// followed by a continuous digit scan onto one shared BCD-to-segment decoder.
module fnd_scan_controller #(
    parameter int P_SCAN_DIV = 100000,
    parameter int P_BLANK    = 2,
    parameter int P_LZ_BLANK = 1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_bcd,
    output logic [3:0]  o_digit_sel
);

    localparam int              CNT_W     = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(P_SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(P_BLANK);
    localparam logic [13:0]     MAX_VAL   = 14'd9999;
    localparam logic [3:0]      BLANK_CODE = 4'hf;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  presc;
    logic [1:0]        idx;
    logic [15:0]       disp;
    logic [3:0]        sh_cnt;
    logic [13:0]       bin_sr;
    logic [15:0]       bcd_acc;
    logic [29:0]       dd_next;
    logic [3:0]        lz_mask;
    logic [3:0]        cur_digit;
    logic              in_blank;
    logic              load_ok;

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [15:0] dabble_adj(input logic [15:0] b);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = (b[4*k +: 4] >= 4'd5) ? b[4*k +: 4] + 4'd3 : b[4*k +: 4];
        end
        return r;
    endfunction

    function automatic logic [13:0] saturate(input logic [13:0] v);
        return (v > MAX_VAL) ? MAX_VAL : v;
    endfunction

    assign dd_next   = {dabble_adj(bcd_acc), bin_sr} << 1;
    assign load_ok   = (state == S_IDLE) && i_load;
    assign in_blank  = (P_BLANK != 0) && (presc < BLANK_END);
    assign cur_digit = disp[{idx, 2'b00} +: 4];

    // A digit is dark when it and every digit above it are zero; the ones digit always shows.
    always_comb begin
        lz_mask    = 4'b0000;
        lz_mask[3] = (P_LZ_BLANK != 0) && (disp[15:12] == 4'd0);
        lz_mask[2] = lz_mask[3] && (disp[11:8] == 4'd0);
        lz_mask[1] = lz_mask[2] && (disp[7:4] == 4'd0);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            presc       <= '0;
            idx         <= 2'd0;
            o_digit_sel <= 4'b1111;
            o_bcd       <= BLANK_CODE;
        end else begin
            if (presc == CNT_LAST) begin
                presc <= '0;
                idx   <= idx + 2'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (in_blank) begin
                o_digit_sel <= 4'b1111;
                o_bcd       <= BLANK_CODE;
            end else begin
                o_digit_sel <= ~(4'b0001 << idx);
                o_bcd       <= lz_mask[idx] ? BLANK_CODE : cur_digit;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= S_IDLE;
            sh_cnt <= 4'd0;
            disp   <= 16'd0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_load) begin
                        sh_cnt <= 4'd0;
                        o_busy <= 1'b1;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sh_cnt <= sh_cnt + 4'd1;
                    if (sh_cnt == 4'd13) begin
                        disp   <= dd_next[29:14];
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Conversion datapath needs no reset: it is always loaded before it is used.
    always_ff @(posedge i_clk) begin
        if (load_ok) begin
            bin_sr  <= saturate(i_value);
            bcd_acc <= 16'd0;
        end else if (state == S_SHIFT) begin
            bin_sr  <= dd_next[13:0];
            bcd_acc <= dd_next[29:14];
        end
    end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: scan pattern, conversion table with scoreboard,
// and the load-collision and reset-abort corner cases.
module tb_fnd_scan_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] value = 14'd0;
    logic        load = 1'b0;
    logic        busy, done, busy_nz, done_nz;
    logic [3:0]  bcd, sel, bcd_nz, sel_nz;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [13:0] value;
        logic [15:0] exp_lz;
        logic [15:0] exp_nz;
    } vec_t;

    typedef struct {
        logic [15:0] lz;
        logic [15:0] nz;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    always #5 clk = ~clk;

    fnd_scan_controller #(.P_SCAN_DIV(4), .P_BLANK(1), .P_LZ_BLANK(1)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_load(load),
        .o_busy(busy), .o_done(done), .o_bcd(bcd), .o_digit_sel(sel)
    );

    fnd_scan_controller #(.P_SCAN_DIV(4), .P_BLANK(1), .P_LZ_BLANK(0)) dut_nz (
        .i_clk(clk), .i_reset_n(rst_n), .i_value(value), .i_load(load),
        .o_busy(busy_nz), .o_done(done_nz), .o_bcd(bcd_nz), .o_digit_sel(sel_nz)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic start_load(input logic [13:0] v, input logic [15:0] e_lz,
                              input logic [15:0] e_nz, input bit push);
        exp_t e;
        value = v;
        load  = 1'b1;
        if (push) begin
            e.lz = e_lz;
            e.nz = e_nz;
            sb.push_back(e);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input int already, output int nbusy, output bit got);
        nbusy = already;
        got   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic scan(output logic [15:0] g_lz, output logic [15:0] g_nz, output bit ok);
        g_lz = 16'heeee;
        g_nz = 16'heeee;
        ok   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (sel)
                4'b1111: if (bcd != 4'hf) ok = 1'b0;
                4'b1110: g_lz[3:0]   = bcd;
                4'b1101: g_lz[7:4]   = bcd;
                4'b1011: g_lz[11:8]  = bcd;
                4'b0111: g_lz[15:12] = bcd;
                default: ok = 1'b0;
            endcase
            case (sel_nz)
                4'b1111: if (bcd_nz != 4'hf) ok = 1'b0;
                4'b1110: g_nz[3:0]   = bcd_nz;
                4'b1101: g_nz[7:4]   = bcd_nz;
                4'b1011: g_nz[11:8]  = bcd_nz;
                4'b0111: g_nz[15:12] = bcd_nz;
                default: ok = 1'b0;
            endcase
        end
    endtask

    task automatic check_conv(input string nm, input int already);
        int nbusy;
        bit got, ok;
        exp_t e;
        logic [15:0] g_lz, g_nz;
        wait_done(already, nbusy, got);
        chk({nm, "_busy_cycles"}, nbusy, 14);
        chk({nm, "_done_seen"}, got, 1);
        @(negedge clk);
        chk({nm, "_done_one_pulse"}, done, 0);
        chk({nm, "_sb_nonempty"}, (sb.size() != 0), 1);
        if (sb.size() != 0) e = sb.pop_front();
        else begin
            e.lz = 16'h0;
            e.nz = 16'h0;
        end
        scan(g_lz, g_nz, ok);
        chk({nm, "_onehot"}, ok, 1);
        chk({nm, "_digits_lz"}, g_lz, e.lz);
        chk({nm, "_digits_nz"}, g_nz, e.nz);
    endtask

    initial begin
        int nbusy;
        bit got, ok;
        exp_t e;
        logic [15:0] g_lz, g_nz;
        logic [3:0] exp_sel, exp_bcd;
        int presc, idx;

        vecs[0] = '{14'd1234,  16'h1234, 16'h1234};
        vecs[1] = '{14'd5,     16'hfff5, 16'h0005};
        vecs[2] = '{14'd1005,  16'h1005, 16'h1005};
        vecs[3] = '{14'd16383, 16'h9999, 16'h9999};
        vecs[4] = '{14'd0,     16'hfff0, 16'h0000};
        vecs[5] = '{14'd10000, 16'h9999, 16'h9999};
        vecs[6] = '{14'd70,    16'hff70, 16'h0070};
        vecs[7] = '{14'd9999,  16'h9999, 16'h9999};

        #7;
        chk("rst_sel", sel, 4'b1111);
        chk("rst_bcd", bcd, 4'hf);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);

        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running scan with display = 0.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            presc   = (k - 1) % 4;
            idx     = (k - 1) / 4;
            exp_sel = (presc == 0) ? 4'b1111 : ~(4'b0001 << idx);
            exp_bcd = (presc == 0) ? 4'hf : ((idx == 0) ? 4'h0 : 4'hf);
            chk($sformatf("scan_sel_%0d", k), sel, exp_sel);
            chk($sformatf("scan_bcd_%0d", k), bcd, exp_bcd);
            chk($sformatf("scan_nz_bcd_%0d", k), bcd_nz, (presc == 0) ? 4'hf : 4'h0);
        end

        // Asynchronous reset in the middle of a lit slot.
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("midslot_pre_sel", sel, 4'b0111);
        rst_n = 1'b0;
        #1;
        chk("midslot_rst_sel", sel, 4'b1111);
        chk("midslot_rst_bcd", bcd, 4'hf);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            start_load(vecs[v].value, vecs[v].exp_lz, vecs[v].exp_nz, 1'b1);
            check_conv($sformatf("vec%0d", v), 0);
        end

        // Load arriving mid-conversion is dropped.
        start_load(14'd1234, 16'h1234, 16'h1234, 1'b1);
        repeat (4) @(negedge clk);
        value = 14'd42;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_conv("ignore42", 5);

        // Load coinciding with the done pulse is accepted.
        start_load(14'd1005, 16'h1005, 16'h1005, 1'b1);
        wait_done(0, nbusy, got);
        chk("lod_first_busy", nbusy, 14);
        chk("lod_first_done", got, 1);
        if (sb.size() != 0) e = sb.pop_front();
        start_load(14'd42, 16'hff42, 16'h0042, 1'b1);
        check_conv("load_on_done", 0);

        // Reset during the seventh shift aborts the conversion.
        start_load(14'd1234, 16'h0, 16'h0, 1'b0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("abort_no_done", got, 0);
        scan(g_lz, g_nz, ok);
        chk("abort_onehot", ok, 1);
        chk("abort_digits_lz", g_lz, 16'hfff0);
        chk("abort_digits_nz", g_nz, 16'h0000);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
